if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline. It is the writer side of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/ready + rvalid handshake, with variable latency.
- Presents each fetched instruction/PC pair to IF/ID. Honours the hazard unit's stall (pc_write) and redirects (branch/jump/flush).
- While no valid instruction is present, drives a NOP bubble so that IF/ID captures a NOP.

---
 rtl/riscv_pipeline_pkg.sv | 21 ++
 rtl/if_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipeline_pkg
// Description : Shared constants and types for the 5-stage RISC-V pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipeline_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0, also used by the IF/ID flush path
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage; owns the PC, fetches one instruction
//               at a time and presents it to the IF/ID register.
//               Optional macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect
//               produces a flagged NOP instead of a memory request).
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = riscv_pipeline_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] fetch_instruction,
   output logic [31:0] fetch_pc,
   output logic        fetch_misaligned
);

   import riscv_pipeline_pkg::*;

   localparam logic [XLEN-1:0] c_align_mask = 32'h0000_0003;
   localparam logic [XLEN-3:0] c_word_inc   = 1;

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_kill;
   logic [XLEN-1:0] r_buf_inst;
   logic [XLEN-1:0] r_buf_pc;
   logic            r_mis;

   logic [XLEN-1:0] w_target;
   logic            w_target_mis;
   logic            w_pc_mis;
   logic [XLEN-1:0] w_pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_target     = redirect_target;
   assign w_target_mis = |redirect_target[1:0];
   assign w_pc_mis     = |r_pc[1:0];
`else
   assign w_target     = redirect_target & ~c_align_mask;
   assign w_target_mis = 1'b0;
   assign w_pc_mis     = 1'b0;
`endif

   // Next sequential PC, aligned down so a misaligned trap PC resumes on a word
   assign w_pc_next = {r_pc[XLEN-1:2] + c_word_inc, 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= REQ;
         r_pc       <= RESET_PC;
         r_kill     <= 1'b0;
         r_buf_inst <= NOP_INSTR;
         r_buf_pc   <= RESET_PC;
         r_mis      <= 1'b0;
      end else begin
         case (r_state)
            REQ: begin
               if (redirect_valid) begin
                  r_pc <= w_target;
                  if (imem_ready) begin
                     r_kill  <= 1'b1;
                     r_state <= WAIT;
                  end else if (w_target_mis) begin
                     r_buf_inst <= NOP_INSTR;
                     r_buf_pc   <= w_target;
                     r_mis      <= 1'b1;
                     r_state    <= HOLD;
                  end
               end else if (imem_ready) begin
                  r_state <= WAIT;
               end
            end

            WAIT: begin
               if (imem_rvalid) begin
                  r_kill <= 1'b0;
                  if (redirect_valid) begin
                     r_pc <= w_target;
                     if (w_target_mis) begin
                        r_buf_inst <= NOP_INSTR;
                        r_buf_pc   <= w_target;
                        r_mis      <= 1'b1;
                        r_state    <= HOLD;
                     end else begin
                        r_state <= REQ;
                     end
                  end else if (r_kill) begin
                     // Stale response dropped; r_pc already holds the redirect target
                     if (w_pc_mis) begin
                        r_buf_inst <= NOP_INSTR;
                        r_buf_pc   <= r_pc;
                        r_mis      <= 1'b1;
                        r_state    <= HOLD;
                     end else begin
                        r_state <= REQ;
                     end
                  end else begin
                     r_buf_inst <= imem_rdata;
                     r_buf_pc   <= r_pc;
                     r_mis      <= 1'b0;
                     r_state    <= HOLD;
                  end
               end else if (redirect_valid) begin
                  r_pc   <= w_target;
                  r_kill <= 1'b1;
               end
            end

            HOLD: begin
               if (redirect_valid) begin
                  r_pc <= w_target;
                  if (w_target_mis) begin
                     r_buf_inst <= NOP_INSTR;
                     r_buf_pc   <= w_target;
                     r_mis      <= 1'b1;
                  end else begin
                     r_mis   <= 1'b0;
                     r_state <= REQ;
                  end
               end else if (pc_write) begin
                  r_pc    <= w_pc_next;
                  r_mis   <= 1'b0;
                  r_state <= REQ;
               end
            end

            default: r_state <= REQ;
         endcase
      end
   end

   assign imem_req          = (r_state == REQ) && !reset;
   assign imem_addr         = r_pc;
   assign fetch_valid       = (r_state == HOLD);
   assign fetch_instruction = (r_state == HOLD) ? r_buf_inst : NOP_INSTR;
   assign fetch_pc          = (r_state == HOLD) ? r_buf_pc : r_pc;
   assign fetch_misaligned  = (r_state == HOLD) && r_mis;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

   localparam logic [31:0] c_nop = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        pc_write;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_instruction;
   logic [31:0] fetch_pc;
   logic        fetch_misaligned;

   int vectors;
   int miscompares;

   if_fetch_unit dut (
      .clk               (clk),
      .reset             (reset),
      .pc_write          (pc_write),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .fetch_valid       (fetch_valid),
      .fetch_instruction (fetch_instruction),
      .fetch_pc          (fetch_pc),
      .fetch_misaligned  (fetch_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One accepted request followed by a latency-1 response; ends in HOLD
   task automatic do_fetch(input logic [31:0] data);
      imem_ready = 1'b1;
      step();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      step();
      imem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
      vectors++; if (fetch_instruction !== c_nop) begin miscompares++; $display("FAIL rst_inst: got %h want %h", fetch_instruction, c_nop); end
      vectors++; if (fetch_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", fetch_pc); end
      vectors++; if (fetch_misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_mis: got %b want 0", fetch_misaligned); end
      reset = 1'b0;
      #1;
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_basic_fetch();
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL basic_wait_req: got %b want 0", imem_req); end
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL basic_wait_valid: got %b want 0", fetch_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hAAAA_AAAA;
      step();
      imem_rvalid = 1'b0;
      vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", fetch_valid); end
      vectors++; if (fetch_pc !== 32'h0) begin miscompares++; $display("FAIL basic_pc: got %h want 0", fetch_pc); end
      vectors++; if (fetch_instruction !== 32'hAAAA_AAAA) begin miscompares++; $display("FAIL basic_inst: got %h want aaaaaaaa", fetch_instruction); end
      pc_write = 1'b1;
      step();
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL basic_next_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL basic_next_addr: got %h want 4", imem_addr); end
   endtask

   task automatic test_stall();
      do_fetch(32'h1111_1111);
      step();
      pc_write = 1'b0;
      do_fetch(32'hBBBB_BBBB);
      for (int i = 0; i < 3; i++) begin
         vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, fetch_valid); end
         vectors++; if (fetch_instruction !== 32'hBBBB_BBBB) begin miscompares++; $display("FAIL stall_inst[%0d]: got %h want bbbbbbbb", i, fetch_instruction); end
         vectors++; if (fetch_pc !== 32'h8) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h want 8", i, fetch_pc); end
         vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
         step();
      end
      pc_write = 1'b1;
      step();
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_resume_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL stall_resume_addr: got %h want c", imem_addr); end
   endtask

   task automatic test_redirect_wait();
      imem_ready = 1'b1;
      step();
      imem_ready      = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      step();
      redirect_valid = 1'b0;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rdw_req: got %b want 0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hCCCC_CCCC;
      step();
      imem_rvalid = 1'b0;
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rdw_valid: got %b want 0", fetch_valid); end
      vectors++; if (fetch_instruction !== c_nop) begin miscompares++; $display("FAIL rdw_inst: got %h want %h", fetch_instruction, c_nop); end
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rdw_next_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL rdw_next_addr: got %h want 100", imem_addr); end
   endtask

   task automatic test_redirect_accept();
      redirect_valid  = 1'b1;
      redirect_target = 32'h10;
      step();
      vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL rda_req_redir_addr: got %h want 10", imem_addr); end
      imem_ready      = 1'b1;
      redirect_target = 32'h40;
      step();
      imem_ready     = 1'b0;
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b1;
      imem_rdata     = 32'h1010_1010;
      step();
      imem_rvalid = 1'b0;
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rda_drop_valid: got %b want 0", fetch_valid); end
      vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL rda_addr: got %h want 40", imem_addr); end
      do_fetch(32'h4040_4040);
      vectors++; if (fetch_pc !== 32'h40) begin miscompares++; $display("FAIL rda_pc: got %h want 40", fetch_pc); end
      vectors++; if (fetch_instruction !== 32'h4040_4040) begin miscompares++; $display("FAIL rda_inst: got %h want 40404040", fetch_instruction); end
   endtask

   task automatic test_redirect_hold();
      pc_write        = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      step();
      redirect_valid = 1'b0;
      vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL rdh_addr: got %h want 200", imem_addr); end
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rdh_valid: got %b want 0", fetch_valid); end
   endtask

   task automatic test_wrap();
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      do_fetch(32'h1234_5678);
      vectors++; if (fetch_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc: got %h want fffffffc", fetch_pc); end
      step();
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_back_to_back();
      imem_ready = 1'b1;
      step();
      imem_ready      = 1'b0;
      imem_rvalid     = 1'b1;
      imem_rdata      = 32'hDEAD_BEEF;
      redirect_valid  = 1'b1;
      redirect_target = 32'h300;
      step();
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid: got %b want 0", fetch_valid); end
      vectors++; if (imem_addr !== 32'h300) begin miscompares++; $display("FAIL b2b_addr: got %h want 300", imem_addr); end
   endtask

   task automatic test_misalign();
      pc_write = 1'b0;
      do_fetch(32'h3030_3030);
      redirect_valid  = 1'b1;
      redirect_target = 32'h102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req: got %b want 0", imem_req); end
      vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL mis_valid: got %b want 1", fetch_valid); end
      vectors++; if (fetch_misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_flag: got %b want 1", fetch_misaligned); end
      vectors++; if (fetch_instruction !== c_nop) begin miscompares++; $display("FAIL mis_inst: got %h want %h", fetch_instruction, c_nop); end
      vectors++; if (fetch_pc !== 32'h102) begin miscompares++; $display("FAIL mis_pc: got %h want 102", fetch_pc); end
      pc_write = 1'b1;
      step();
      vectors++; if (imem_addr !== 32'h104) begin miscompares++; $display("FAIL mis_exit_addr: got %h want 104", imem_addr); end
`else
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL mis_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL mis_addr: got %h want 100", imem_addr); end
      vectors++; if (fetch_misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_flag: got %b want 0", fetch_misaligned); end
      pc_write = 1'b1;
`endif
   endtask

   task automatic test_reset_mid();
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      reset      = 1'b1;
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req: got %b want 0", imem_req); end
      vectors++; if (fetch_pc !== 32'h0) begin miscompares++; $display("FAIL rmid_pc: got %h want 0", fetch_pc); end
      step();
      reset = 1'b0;
      #1;
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_req_after: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_addr: got %h want 0", imem_addr); end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      reset           = 1'b1;
      pc_write        = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      imem_ready      = 1'b0;
      imem_rvalid     = 1'b0;
      imem_rdata      = 32'h0;

      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_wait();
      test_redirect_accept();
      test_redirect_hold();
      test_wrap();
      test_back_to_back();
      test_misalign();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
